// File: rtl/util_ext_sync_ctrl.sv
// util_ext_sync_ctrl: arms an external sync register, captures synchronized sync_in edges and disarms,
// supervising each wait state with an optional cycle timeout.
module util_ext_sync_ctrl #(
  parameter int TIMEOUT_W = 16,
  parameter int COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_enable,
  input  logic                 cfg_oneshot,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 arm_req,
  input  logic                 disarm_req,
  input  logic                 err_clr,
  input  logic                 sync_in,
  input  logic                 sync_armed,
  output logic                 ext_sync_arm,
  output logic                 ext_sync_disarm,
  output logic                 sync_out,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [COUNT_W-1:0]   capture_count
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_ACK, WAIT_EDGE, DISARM, WAIT_DROP, FAIL} state_t;
  state_t state, state_nx;
  logic s1, s2, s3;
  logic [TIMEOUT_W-1:0] tcnt, tcnt_nx;
  logic edge_det, abort, waiting, tmo, err_set;
  // A wait state lasts at most cfg_timeout cycles before the timeout fires.
  always_comb begin
    edge_det = state == WAIT_EDGE && s2 && !s3;
    abort = (disarm_req || !cfg_enable) && (state == ARM || state == WAIT_ACK || state == WAIT_EDGE);
    waiting = state == WAIT_ACK || state == WAIT_EDGE || state == WAIT_DROP;
    tmo = waiting && cfg_timeout != '0 && tcnt + TIMEOUT_W'(1) == cfg_timeout;
    state_nx = state;
    case (state)
      IDLE:      state_nx = (arm_req && cfg_enable) ? ARM : IDLE;
      ARM:       state_nx = abort ? DISARM : WAIT_ACK;
      WAIT_ACK:  state_nx = abort ? DISARM : sync_armed ? WAIT_EDGE : tmo ? FAIL : WAIT_ACK;
      WAIT_EDGE: state_nx = abort ? DISARM : edge_det ? (cfg_oneshot ? DISARM : WAIT_EDGE) : tmo ? FAIL : WAIT_EDGE;
      DISARM:    state_nx = WAIT_DROP;
      FAIL:      state_nx = WAIT_DROP;
      WAIT_DROP: state_nx = (!sync_armed || tmo) ? IDLE : WAIT_DROP;
      default:   state_nx = IDLE;
    endcase
    err_set = state_nx == FAIL || (state == WAIT_DROP && sync_armed && tmo);
    tcnt_nx = (!waiting || state_nx != state || edge_det) ? '0 : tcnt + TIMEOUT_W'(1);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      {s1, s2, s3} <= '0;
      tcnt <= '0;
      sync_out <= 1'b0;
      timeout_err <= 1'b0;
      capture_count <= '0;
    end else begin
      state <= state_nx;
      {s1, s2, s3} <= {sync_in, s1, s2};
      tcnt <= tcnt_nx;
      sync_out <= edge_det;
      timeout_err <= err_set || (timeout_err && !err_clr);
      if (state == IDLE && state_nx == ARM)
        capture_count <= '0;
      else if (edge_det && !(&capture_count))
        capture_count <= capture_count + COUNT_W'(1);
    end
  end
  assign ext_sync_arm = state == ARM;
  assign ext_sync_disarm = state == DISARM || state == FAIL;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_util_ext_sync_ctrl.sv
// tb_util_ext_sync_ctrl: vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_util_ext_sync_ctrl;
  logic clk = 0, resetn = 1, cfg_enable = 1, cfg_oneshot = 1, arm_req = 0, disarm_req = 0, err_clr = 0;
  logic sync_in = 0, sync_armed = 0;
  logic [15:0] cfg_timeout = 0;
  logic ext_sync_arm, ext_sync_disarm, sync_out, busy, timeout_err;
  logic [7:0] capture_count;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  util_ext_sync_ctrl dut (
    .clk(clk), .resetn(resetn), .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot),
    .cfg_timeout(cfg_timeout), .arm_req(arm_req), .disarm_req(disarm_req), .err_clr(err_clr),
    .sync_in(sync_in), .sync_armed(sync_armed), .ext_sync_arm(ext_sync_arm),
    .ext_sync_disarm(ext_sync_disarm), .sync_out(sync_out), .busy(busy),
    .timeout_err(timeout_err), .capture_count(capture_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [12:0] outs();
    return {ext_sync_arm, ext_sync_disarm, sync_out, busy, timeout_err, capture_count};
  endfunction

  // Behavioural model: phase names follow the documented states, sync_in history kept as a 3-deep shift.
  localparam int M_IDLE = 0, M_ARM = 1, M_WA = 2, M_WE = 3, M_DIS = 4, M_WD = 5, M_FAIL = 6;
  int ph, tc, cnt;
  bit h1, h2, h3, err, so;

  task automatic m_reset();
    ph = M_IDLE; tc = 0; cnt = 0; {h1, h2, h3} = '0; err = 0; so = 0;
  endtask

  task automatic m_step();
    bit edge_seen, stop, waits, expired;
    int nx;
    edge_seen = ph == M_WE && h2 && !h3;
    stop = (disarm_req || !cfg_enable) && ph inside {M_ARM, M_WA, M_WE};
    waits = ph inside {M_WA, M_WE, M_WD};
    expired = waits && cfg_timeout != 0 && tc + 1 == int'(cfg_timeout);
    nx = ph;
    if (ph == M_IDLE && arm_req && cfg_enable) nx = M_ARM;
    else if (stop) nx = M_DIS;
    else if (ph == M_ARM) nx = M_WA;
    else if (ph == M_WA && sync_armed) nx = M_WE;
    else if (ph == M_WE && edge_seen) nx = cfg_oneshot ? M_DIS : M_WE;
    else if (ph == M_DIS || ph == M_FAIL) nx = M_WD;
    else if (ph == M_WD && (!sync_armed || expired)) nx = M_IDLE;
    else if (expired) nx = M_FAIL;
    if (nx == M_FAIL || (ph == M_WD && sync_armed && expired)) err = 1;
    else if (err_clr) err = 0;
    so = edge_seen;
    if (ph == M_IDLE && nx == M_ARM) cnt = 0;
    else if (edge_seen && cnt < 255) cnt++;
    tc = (waits && nx == ph && !edge_seen) ? tc + 1 : 0;
    h3 = h2; h2 = h1; h1 = sync_in;
    ph = nx;
  endtask

  function automatic logic [12:0] m_outs();
    return {ph == M_ARM, ph == M_DIS || ph == M_FAIL, so, ph != M_IDLE, err, 8'(cnt)};
  endfunction

  typedef struct {
    bit arm, dis, sin, sack;
    bit [4:0] e_flags;
    int e_cnt;
  } vec_t;
  vec_t vt[10];

  initial begin
    int n, pulses, disarms;
    bit seen;
    vt[0] = '{1, 0, 0, 0, 5'b10010, 0};
    vt[1] = '{0, 0, 0, 0, 5'b00010, 0};
    vt[2] = '{0, 0, 0, 0, 5'b00010, 0};
    vt[3] = '{0, 0, 0, 1, 5'b00010, 0};
    vt[4] = '{0, 0, 1, 1, 5'b00010, 0};
    vt[5] = '{0, 0, 0, 1, 5'b00010, 0};
    vt[6] = '{0, 0, 0, 1, 5'b01110, 1};
    vt[7] = '{0, 0, 0, 1, 5'b00010, 1};
    vt[8] = '{0, 0, 0, 0, 5'b00000, 1};
    vt[9] = '{0, 1, 0, 0, 5'b00000, 1};
    #1 resetn = 0;
    repeat (3) step();
    check("reset_outs", 32'(outs()), 0);
    resetn = 1;
    step();
    // oneshot sequence from the vector table
    for (int i = 0; i < 10; i++) begin
      {arm_req, disarm_req, sync_in, sync_armed} = {vt[i].arm, vt[i].dis, vt[i].sin, vt[i].sack};
      step();
      check($sformatf("vec%0d", i), 32'(outs()), {19'd0, vt[i].e_flags, 8'(vt[i].e_cnt)});
    end
    disarm_req = 0;
    // continuous capture with saturation
    cfg_oneshot = 0;
    arm_req = 1; step(); arm_req = 0; sync_armed = 1;
    step(); step();
    pulses = 0; disarms = 0;
    for (int i = 0; i < 300; i++) begin
      sync_in = 1; step(); pulses += int'(sync_out); disarms += int'(ext_sync_disarm);
      sync_in = 0; step(); pulses += int'(sync_out); disarms += int'(ext_sync_disarm);
    end
    repeat (4) begin step(); pulses += int'(sync_out); disarms += int'(ext_sync_disarm); end
    check("cont_pulses", pulses, 300);
    check("cont_count", capture_count, 255);
    check("cont_busy", busy, 1);
    check("cont_disarms", disarms, 0);
    disarm_req = 1; step(); disarm_req = 0;
    check("req_disarm", ext_sync_disarm, 1);
    step(); sync_armed = 0; step();
    check("cont_idle", busy, 0);
    // abort coinciding with a detected edge
    arm_req = 1; step(); arm_req = 0; sync_armed = 1;
    step(); step();
    sync_in = 1; step(); sync_in = 0; step();
    disarm_req = 1; step(); disarm_req = 0;
    check("abort_flags", {ext_sync_disarm, sync_out, capture_count}, {1'b1, 1'b1, 8'd1});
    step(); sync_armed = 0; step();
    check("abort_idle", busy, 0);
    // acknowledge timeout
    cfg_timeout = 10;
    arm_req = 1; step(); arm_req = 0;
    n = 0; seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (ext_sync_disarm) seen = 1;
      else if (busy && !ext_sync_arm) n++;
    end
    check("tmo_seen", seen, 1);
    check("tmo_wait_cycles", n, 10);
    check("tmo_err_set", timeout_err, 1);
    step();
    check("tmo_single_disarm", ext_sync_disarm, 0);
    step();
    check("tmo_idle", {busy, timeout_err}, 2'b01);
    err_clr = 1; step(); err_clr = 0;
    check("tmo_err_clr", timeout_err, 0);
    cfg_timeout = 0;
    // reset in the middle of WAIT_EDGE
    arm_req = 1; step(); arm_req = 0; sync_armed = 1;
    step(); step();
    sync_in = 1; step(); sync_in = 0; step(); step();
    check("pre_rst_count", capture_count, 1);
    #1 resetn = 0;
    #1 check("rst_mid_outs", 32'(outs()), 0);
    step();
    check("rst_hold_outs", 32'(outs()), 0);
    resetn = 1; sync_armed = 0;
    step();
    arm_req = 1; step(); arm_req = 0;
    check("rst_rearm", 32'(outs()), {19'd0, 5'b10010, 8'd0});
    // randomized run against the model
    resetn = 0; step();
    {arm_req, disarm_req, err_clr, sync_in, sync_armed} = '0;
    cfg_enable = 1;
    resetn = 1;
    m_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        cfg_oneshot = 1'($urandom_range(0, 1));
        cfg_timeout = 16'($urandom_range(0, 8));
      end
      cfg_enable = $urandom_range(0, 15) != 0;
      arm_req = $urandom_range(0, 3) == 0;
      disarm_req = $urandom_range(0, 15) == 0;
      err_clr = $urandom_range(0, 15) == 0;
      sync_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) sync_armed = !sync_armed;
      m_step();
      step();
      check($sformatf("rand%0d", i), 32'(outs()), 32'(m_outs()));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/util_ext_sync_ctrl.md
UTIL_EXT_SYNC_CTRL -- requirements
Module: util_ext_sync_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of the timeout counter and cfg_timeout.
REQ-002 SHALL have parameter COUNT_W, default 8, width of capture_count.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port cfg_enable, input, 1, controller enable; low forces disarm.
REQ-006 SHALL have port cfg_oneshot, input, 1, 1 = disarm after first capture, 0 = continuous.
REQ-007 SHALL have port cfg_timeout, input, TIMEOUT_W, cycles allowed per wait state; 0 = no timeout.
REQ-008 SHALL have port arm_req, input, 1, single-cycle request to start a sync sequence.
REQ-009 SHALL have port disarm_req, input, 1, single-cycle request to abort or stop.
REQ-010 SHALL have port err_clr, input, 1, clears timeout_err.
REQ-011 SHALL have port sync_in, input, 1, external sync, asynchronous to clk.
REQ-012 SHALL have port sync_armed, input, 1, armed status returned by the arming register.
REQ-013 SHALL have port ext_sync_arm, output, 1, single-cycle arm pulse to the arming register.
REQ-014 SHALL have port ext_sync_disarm, output, 1, single-cycle disarm pulse to the arming register.
REQ-015 SHALL have port sync_out, output, 1, single-cycle pulse per captured sync_in rising edge.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port timeout_err, output, 1, sticky timeout flag.
REQ-018 SHALL have port capture_count, output, COUNT_W, number of captures since last arm.

Function
REQ-019 SHALL synchronize sync_in through two flops, then register it once more for rising-edge detection.
- sync_in high before clk edge N gives sync_out high in the cycle after edge N+2.
REQ-020 SHALL implement the states IDLE, ARM, WAIT_ACK, WAIT_EDGE, DISARM, WAIT_DROP and FAIL.
REQ-021 SHALL leave IDLE for ARM only when arm_req=1 and cfg_enable=1; arm_req is ignored in all other states.
REQ-022 SHALL assert ext_sync_arm in ARM only, for exactly 1 cycle, then go to WAIT_ACK.
- On entering ARM: capture_count cleared to 0, timeout counter cleared.
REQ-023 SHALL go from WAIT_ACK to WAIT_EDGE when sync_armed=1.
REQ-024 SHALL, in WAIT_EDGE, act on each detected edge as follows:
- pulse sync_out;
- increment capture_count, saturating at all-ones;
- clear the timeout counter;
- cfg_oneshot=1: go to DISARM; cfg_oneshot=0: stay in WAIT_EDGE.
REQ-025 SHALL generate no sync_out outside WAIT_EDGE; edges elsewhere are dropped.
REQ-026 SHALL count cycles with the timeout counter in WAIT_ACK, WAIT_EDGE and WAIT_DROP.
- cfg_timeout≠0 and count = cfg_timeout: go to FAIL.
- Counter clears on every state change.
REQ-027 SHALL, in FAIL, set timeout_err and assert ext_sync_disarm for 1 cycle, then go to WAIT_DROP.
REQ-028 SHALL assert ext_sync_disarm in DISARM for 1 cycle, then go to WAIT_DROP.
REQ-029 SHALL go from WAIT_DROP to IDLE when sync_armed=0.
- A timeout in WAIT_DROP sets timeout_err and goes directly to IDLE.
REQ-030 SHALL, when disarm_req=1 or cfg_enable=0 in ARM, WAIT_ACK or WAIT_EDGE, go to DISARM next cycle.
- This has priority over edge-driven and timeout transitions.
- An edge in the same cycle is still counted and pulsed.
REQ-031 SHALL resolve simultaneous err_clr and timeout-set to timeout_err=1.
REQ-032 SHALL never assert ext_sync_arm and ext_sync_disarm in the same cycle.

Reset
REQ-033 SHALL, while resetn=0, force the following regardless of clk:
- state = IDLE;
- ext_sync_arm=0, ext_sync_disarm=0, sync_out=0, busy=0, timeout_err=0;
- capture_count=0;
- synchronizer flops and timeout counter = 0.
REQ-034 SHALL, on reset asserted mid-sequence, issue no disarm pulse; the arming register is reset separately.
REQ-035 SHALL resume normal operation on the first clk edge after resetn deasserts.

Verification
REQ-036 SHALL pass oneshot: cfg_oneshot=1, cfg_timeout=0, arm_req, sync_armed follows 2 cycles later, one sync_in pulse.
- Expect: one ext_sync_arm pulse, one sync_out 3 cycles after sync_in, capture_count=1, one ext_sync_disarm, IDLE once sync_armed=0.
REQ-037 SHALL pass continuous: cfg_oneshot=0, 300 sync_in edges with COUNT_W=8.
- Expect: 300 sync_out pulses, capture_count saturates at 255, state stays WAIT_EDGE.
REQ-038 SHALL pass ack timeout: cfg_timeout=10, sync_armed held 0 after arm.
- Expect: FAIL 10 cycles into WAIT_ACK, timeout_err=1, one ext_sync_disarm; err_clr then gives timeout_err=0.
REQ-039 SHALL pass abort: disarm_req in the same cycle as a detected edge in WAIT_EDGE, continuous mode.
- Expect: sync_out pulse, capture_count+1, DISARM next cycle.
REQ-040 SHALL pass reset mid-sequence: resetn low during WAIT_EDGE.
- Expect: all outputs 0 immediately with no disarm pulse; after release, arm_req restarts the sequence normally.
